// File: rtl/sprite_pixel_fetch_if.sv
// Sprite colour ROM read port: registered-address ROM with one cycle of read latency.
// The master (fetch) drives row/col and the slave (ROM) returns the colour.
interface sprite_pixel_fetch_if;
  logic [4:0]  rom_row;
  logic [4:0]  rom_col;
  logic [11:0] rom_data;

  modport master (
    output rom_row,
    output rom_col,
    input  rom_data
  );

  modport slave (
    input  rom_row,
    input  rom_col,
    output rom_data
  );
endinterface

// File: rtl/sprite_pixel_fetch.sv
// Sprite pixel fetch: hit test, ROM addressing, transparency key and a frame-synchronous
// double-buffered position. Define SPRITE_MIRROR_EN for horizontal flip via facing_left_i.
module sprite_pixel_fetch #(
  parameter int unsigned SPR_W     = 16,
  parameter int unsigned SPR_H     = 16,
  parameter logic [11:0] KEY_COLOR = 12'b011011001100,
  parameter logic [9:0]  INIT_X    = 10'd0,
  parameter logic [9:0]  INIT_Y    = 10'd0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [9:0]                  x_i,
  input  logic [9:0]                  y_i,
  input  logic                        video_on_i,
  input  logic                        frame_start_i,
  input  logic                        pos_wr_i,
  input  logic [9:0]                  pos_x_i,
  input  logic [9:0]                  pos_y_i,
  input  logic                        facing_left_i,
  output logic                        pos_pending_o,
  sprite_pixel_fetch_if.master        rom_if,
  output logic [11:0]                 pix_rgb_o,
  output logic                        pix_hit_o,
  output logic                        pix_video_on_o
);

  typedef enum logic {StClean, StPending} state_e;

  state_e     state_q, state_d;
  logic [9:0] cx_q, cx_d, cy_q, cy_d;
  logic [9:0] px_q, px_d, py_q, py_d;
  logic       hit_s1_q, video_on_s1_q;
  logic [11:0] pix_rgb_q;
  logic        pix_hit_q, pix_video_on_q;

`ifdef SPRITE_MIRROR_EN
  logic cface_q, cface_d, pface_q, pface_d;
`else
  logic unused_facing_left;
  assign unused_facing_left = facing_left_i;
`endif

  always_comb begin
    state_d = state_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    px_d    = px_q;
    py_d    = py_q;
`ifdef SPRITE_MIRROR_EN
    cface_d = cface_q;
    pface_d = pface_q;
`endif
    if (pos_wr_i && frame_start_i) begin
      // Simultaneous write and frame start: the fresh position wins over any pending one.
      cx_d    = pos_x_i;
      cy_d    = pos_y_i;
`ifdef SPRITE_MIRROR_EN
      cface_d = facing_left_i;
`endif
      state_d = StClean;
    end else if (pos_wr_i) begin
      px_d    = pos_x_i;
      py_d    = pos_y_i;
`ifdef SPRITE_MIRROR_EN
      pface_d = facing_left_i;
`endif
      state_d = StPending;
    end else if (frame_start_i && (state_q == StPending)) begin
      cx_d    = px_q;
      cy_d    = py_q;
`ifdef SPRITE_MIRROR_EN
      cface_d = pface_q;
`endif
      state_d = StClean;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StClean;
      cx_q    <= INIT_X;
      cy_q    <= INIT_Y;
      px_q    <= 10'd0;
      py_q    <= 10'd0;
`ifdef SPRITE_MIRROR_EN
      cface_q <= 1'b0;
      pface_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      px_q    <= px_d;
      py_q    <= py_d;
`ifdef SPRITE_MIRROR_EN
      cface_q <= cface_d;
      pface_q <= pface_d;
`endif
    end
  end

  assign pos_pending_o = (state_q == StPending);

  // 11-bit compare so a box near x=639 clips instead of wrapping to column 0.
  logic [10:0] x_w, y_w, cx_w, cy_w, x_end, y_end;
  logic        hit;
  logic [4:0]  col_raw, row_raw, col_sel;

  assign x_w   = {1'b0, x_i};
  assign y_w   = {1'b0, y_i};
  assign cx_w  = {1'b0, cx_q};
  assign cy_w  = {1'b0, cy_q};
  assign x_end = cx_w + 11'(SPR_W);
  assign y_end = cy_w + 11'(SPR_H);

  assign hit = video_on_i && (x_w >= cx_w) && (x_w < x_end) &&
               (y_w >= cy_w) && (y_w < y_end);

  assign col_raw = x_i[4:0] - cx_q[4:0];
  assign row_raw = y_i[4:0] - cy_q[4:0];

`ifdef SPRITE_MIRROR_EN
  assign col_sel = cface_q ? (5'(SPR_W - 1) - col_raw) : col_raw;
`else
  assign col_sel = col_raw;
`endif

  assign rom_if.rom_row = hit ? row_raw : 5'd0;
  assign rom_if.rom_col = hit ? col_sel : 5'd0;

  logic opaque;
  assign opaque = hit_s1_q && (rom_if.rom_data != KEY_COLOR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_s1_q       <= 1'b0;
      video_on_s1_q  <= 1'b0;
      pix_hit_q      <= 1'b0;
      pix_rgb_q      <= 12'h000;
      pix_video_on_q <= 1'b0;
    end else begin
      hit_s1_q       <= hit;
      video_on_s1_q  <= video_on_i;
      pix_hit_q      <= opaque;
      pix_rgb_q      <= opaque ? rom_if.rom_data : 12'h000;
      pix_video_on_q <= video_on_s1_q;
    end
  end

  assign pix_rgb_o      = pix_rgb_q;
  assign pix_hit_o      = pix_hit_q;
  assign pix_video_on_o = pix_video_on_q;

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Directed bench for sprite_pixel_fetch with a registered-address ROM model; checks addresses
// in the same cycle and pixel outputs two clocks after each driven coordinate.
module tb_sprite_pixel_fetch;
  localparam logic [11:0] KEY = 12'b011011001100;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [9:0]  x_i = '0, y_i = '0, pos_x_i = '0, pos_y_i = '0;
  logic        video_on_i = 1'b0, frame_start_i = 1'b0, pos_wr_i = 1'b0, facing_left_i = 1'b0;
  logic        pos_pending_o, pix_hit_o, pix_video_on_o;
  logic [11:0] pix_rgb_o;

  int n_cmp = 0;
  int n_err = 0;

  // Expected-output pipe: index 0 is the input currently held, index 1 the one before.
  logic        pv [2];
  logic        ph [2];
  logic [11:0] pr [2];
  logic        pvo[2];

  sprite_pixel_fetch_if rom_if ();

  sprite_pixel_fetch #(
    .SPR_W    (16),
    .SPR_H    (16),
    .KEY_COLOR(KEY),
    .INIT_X   (10'd100),
    .INIT_Y   (10'd50)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .x_i           (x_i),
    .y_i           (y_i),
    .video_on_i    (video_on_i),
    .frame_start_i (frame_start_i),
    .pos_wr_i      (pos_wr_i),
    .pos_x_i       (pos_x_i),
    .pos_y_i       (pos_y_i),
    .facing_left_i (facing_left_i),
    .pos_pending_o (pos_pending_o),
    .rom_if        (rom_if.master),
    .pix_rgb_o     (pix_rgb_o),
    .pix_hit_o     (pix_hit_o),
    .pix_video_on_o(pix_video_on_o)
  );

  always #5 clk_i = ~clk_i;

  // Column 5 of every row is transparent; otherwise the colour encodes row/col.
  function automatic logic [11:0] rom_fn(input logic [4:0] r, input logic [4:0] c);
    return (c == 5'd5) ? KEY : {2'b00, r, c};
  endfunction

  initial rom_if.rom_data = 12'h000;
  always @(posedge clk_i) rom_if.rom_data <= rom_fn(rom_if.rom_row, rom_if.rom_col);

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    if (pv[1]) begin
      chk("pix_hit", {11'd0, pix_hit_o}, {11'd0, ph[1]});
      chk("pix_rgb", pix_rgb_o, pr[1]);
      chk("pix_video_on", {11'd0, pix_video_on_o}, {11'd0, pvo[1]});
    end
    pv[1] = pv[0]; ph[1] = ph[0]; pr[1] = pr[0]; pvo[1] = pvo[0];
  endtask

  task automatic pix(input int xx, input int yy, input logic von, input logic h,
                     input int row, input int col);
    logic [11:0] c;
    tick();
    x_i = 10'(xx); y_i = 10'(yy); video_on_i = von;
    #1;
    chk("rom_row", {7'd0, rom_if.rom_row}, h ? 12'(row) : 12'd0);
    chk("rom_col", {7'd0, rom_if.rom_col}, h ? 12'(col) : 12'd0);
    c = rom_fn(5'(row), 5'(col));
    pv[0]  = 1'b1;
    ph[0]  = h && (c != KEY);
    pr[0]  = (h && (c != KEY)) ? c : 12'h000;
    pvo[0] = von;
  endtask

  task automatic ctl(input logic wr, input int xx, input int yy, input logic face,
                     input logic fs);
    tick();
    video_on_i = 1'b0;
    pv[0] = 1'b1; ph[0] = 1'b0; pr[0] = 12'h000; pvo[0] = 1'b0;
    pos_wr_i = wr; pos_x_i = 10'(xx); pos_y_i = 10'(yy); facing_left_i = face;
    frame_start_i = fs;
    tick();
    pos_wr_i = 1'b0; frame_start_i = 1'b0; facing_left_i = 1'b0;
  endtask

  task automatic do_reset();
    tick();
    video_on_i = 1'b0;
    rst_ni = 1'b0;
    pv[0] = 1'b0; pv[1] = 1'b0;
    #1;
    chk("rst_pending", {11'd0, pos_pending_o}, 12'd0);
    chk("rst_hit", {11'd0, pix_hit_o}, 12'd0);
    chk("rst_rgb", pix_rgb_o, 12'h000);
    chk("rst_video_on", {11'd0, pix_video_on_o}, 12'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin
    pv[0] = 1'b0; pv[1] = 1'b0;
    ph[0] = 1'b0; ph[1] = 1'b0;
    pr[0] = '0;   pr[1] = '0;
    pvo[0] = 1'b0; pvo[1] = 1'b0;

    do_reset();

    // Scan the initial box row 0; column 5 is keyed out.
    for (int i = 0; i < 16; i++) pix(100 + i, 50, 1'b1, 1'b1, 0, i);
    pix(116, 50, 1'b1, 1'b0, 0, 0);
    pix(99, 50, 1'b1, 1'b0, 0, 0);

    // Mid-frame write stays pending until frame start.
    ctl(1'b1, 200, 80, 1'b0, 1'b0);
    chk("pending_after_wr", {11'd0, pos_pending_o}, 12'd1);
    pix(101, 50, 1'b1, 1'b1, 0, 1);
    pix(200, 80, 1'b1, 1'b0, 0, 0);
    ctl(1'b0, 0, 0, 1'b0, 1'b1);
    chk("pending_after_fs", {11'd0, pos_pending_o}, 12'd0);
    for (int i = 0; i < 4; i++) pix(200 + i, 80, 1'b1, 1'b1, 0, i);
    pix(215, 95, 1'b1, 1'b1, 15, 15);
    pix(216, 95, 1'b1, 1'b0, 0, 0);
    pix(215, 96, 1'b1, 1'b0, 0, 0);
    pix(100, 50, 1'b1, 1'b0, 0, 0);

    // Last write wins.
    ctl(1'b1, 10, 10, 1'b0, 1'b0);
    ctl(1'b1, 20, 20, 1'b0, 1'b0);
    chk("pending_two_wr", {11'd0, pos_pending_o}, 12'd1);
    ctl(1'b0, 0, 0, 1'b0, 1'b1);
    pix(20, 20, 1'b1, 1'b1, 0, 0);
    pix(10, 10, 1'b1, 1'b0, 0, 0);
    pix(27, 22, 1'b1, 1'b1, 2, 7);
    pix(25, 22, 1'b1, 1'b1, 2, 5);

    // Write together with frame start commits at once.
    ctl(1'b1, 300, 300, 1'b0, 1'b1);
    chk("pending_wr_fs", {11'd0, pos_pending_o}, 12'd0);
    pix(300, 300, 1'b1, 1'b1, 0, 0);
    pix(315, 315, 1'b1, 1'b1, 15, 15);
    pix(316, 300, 1'b1, 1'b0, 0, 0);

    // Right-edge clipping, no wrap, video_on gating.
    ctl(1'b1, 630, 100, 1'b0, 1'b1);
    pix(629, 100, 1'b1, 1'b0, 0, 0);
    for (int i = 0; i < 10; i++) pix(630 + i, 100, 1'b1, 1'b1, 0, i);
    pix(0, 100, 1'b1, 1'b0, 0, 0);
    pix(632, 103, 1'b0, 1'b0, 0, 0);
    // Frame start with nothing pending leaves the position alone.
    ctl(1'b0, 0, 0, 1'b0, 1'b1);
    chk("pending_idle_fs", {11'd0, pos_pending_o}, 12'd0);
    pix(631, 101, 1'b1, 1'b1, 1, 1);

    // Reset discards a pending write and restores the initial position.
    ctl(1'b1, 5, 5, 1'b0, 1'b0);
    chk("pending_before_rst", {11'd0, pos_pending_o}, 12'd1);
    do_reset();
    chk("pending_after_rst", {11'd0, pos_pending_o}, 12'd0);
    pix(100, 50, 1'b1, 1'b1, 0, 0);
    pix(5, 5, 1'b1, 1'b0, 0, 0);
    ctl(1'b0, 0, 0, 1'b0, 1'b1);
    pix(631, 100, 1'b1, 1'b0, 0, 0);

    // facing_left: flips columns only when mirroring is built.
    ctl(1'b1, 100, 50, 1'b1, 1'b1);
`ifdef SPRITE_MIRROR_EN
    pix(100, 50, 1'b1, 1'b1, 0, 15);
    pix(115, 50, 1'b1, 1'b1, 0, 0);
    pix(110, 51, 1'b1, 1'b1, 1, 5);
`else
    pix(100, 50, 1'b1, 1'b1, 0, 0);
    pix(115, 50, 1'b1, 1'b1, 0, 15);
    pix(110, 51, 1'b1, 1'b1, 1, 10);
`endif
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sprite_pixel_fetch.md
# sprite_pixel_fetch

Reader side of the sprite colour ROMs: maps the VGA pixel coordinate stream to ROM row/col addresses, absorbs the ROM's one-cycle registered-address latency and applies the transparency key. Outputs a pipelined sprite pixel for the pixel mux. Position updates from game logic are double-buffered and committed only at frame start, so a sprite never tears mid-frame.

## Interface
- SPR_W, 16: sprite width in pixels, 1..32
- SPR_H, 16: sprite height in pixels, 1..32
- KEY_COLOR, 12'b011011001100: transparent colour
- INIT_X, 10'd0: committed x after reset
- INIT_Y, 10'd0: committed y after reset

- clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- x  in  10  current pixel column from the VGA timing generator
- y  in  10  current pixel row
- video_on  in  1  visible-area flag for x/y
- frame_start  in  1  one-cycle pulse at the first pixel of vertical blank
- pos_wr  in  1  one-cycle write strobe for the new sprite position
- pos_x  in  10  new top-left x, sampled on pos_wr
- pos_y  in  10  new top-left y, sampled on pos_wr
- facing_left  in  1  sampled on pos_wr; used only with SPRITE_MIRROR_EN
- pos_pending  out  1  written position not yet committed
- rom_row  out  5  ROM row address (combinational)
- rom_col  out  5  ROM column address (combinational)
- rom_data  in  12  ROM colour, valid one cycle after its address
- pix_rgb  out  12  sprite colour, or 12'h000 when not hit
- pix_hit  out  1  opaque sprite pixel present
- pix_video_on  out  1  video_on delayed to align with pix_rgb

## Operation
- Registers:
  - committed position (cx, cy, cface)
  - pending position (px, py, pface)
- Two-state FSM:
  - CLEAN: pos_pending=0.
  - PENDING: pos_pending=1.
  - CLEAN: pos_wr loads the pending registers and moves to PENDING. frame_start has no effect.
  - PENDING: pos_wr overwrites the pending registers (last write wins). frame_start copies pending to committed and moves to CLEAN.
  - pos_wr and frame_start in the same cycle (either state): the incoming pos_x/pos_y/facing_left commit directly; state becomes CLEAN.
- Hit test, in 11-bit unsigned arithmetic (no wrap):
  - hit = video_on && x>=cx && x<cx+SPR_W && y>=cy && y<cy+SPR_H.
  - Sprites partially off-screen (cx+SPR_W>639) are clipped naturally.
- Addressing:
  - rom_row = (y-cy)[4:0] and rom_col = (x-cx)[4:0] when hit.
  - Both are 0 when not hit.
- Stage 1 registers hit_d and video_on_d.
- Stage 2 output register, with opaque = hit_d && rom_data!=KEY_COLOR:
  - pix_hit <= opaque.
  - pix_rgb <= opaque ? rom_data : 12'h000.
  - pix_video_on <= video_on_d.
- Reset: all registers clear asynchronously.
  - committed = INIT_X/INIT_Y, cface=0; pending cleared; state CLEAN.
  - pix_rgb=0, pix_hit=0, pix_video_on=0, pos_pending=0; hit_d=0, video_on_d=0.
  - A reset mid-frame discards any pending write.

## Timing
- Address is combinational from x/y and the committed position, in the same cycle.
- Latency x/y to pix_* is exactly 2 clocks: ROM address register, then output register. Throughput is one pixel per clock.
- The committed position changes on the clock edge at which frame_start is high. Pixels presented from the next cycle onward use the new value.
- pos_pending rises the cycle after pos_wr and falls the cycle after the commit.

## Configuration
- SPRITE_MIRROR_EN defined:
  - When cface=1, rom_col = SPR_W-1-(x-cx) (horizontal flip).
  - facing_left is stored with the position and committed with it.
- SPRITE_MIRROR_EN undefined:
  - facing_left is ignored; cface/pface registers are not built.
  - rom_col is always x-cx.

## Test plan
- Reset with INIT_X=100, INIT_Y=50, then scan x=100..115 at y=50 -> rom_row=0, rom_col=0..15; with a ROM model, pix_hit follows 2 cycles later; pix_rgb=0 where the ROM returns KEY_COLOR.
- pos_wr (200,80) mid-frame -> pos_pending=1, pixels still hit at (100,50); after frame_start, hit at (200,80) and pos_pending=0.
- pos_wr (10,10), then pos_wr (20,20), then frame_start -> commits (20,20) only.
- pos_wr (300,300) together with frame_start -> immediate commit, pos_pending stays 0.
- Position cx=630, scan to x=639 -> hits at 630..639 only; no hit at x=0 (no wrap). video_on=0 inside the box -> pix_hit=0.
- With SPRITE_MIRROR_EN, facing_left=1, cx=100 -> x=100 gives rom_col=15, x=115 gives rom_col=0.
